// File: rtl/calibration_pkg.sv
// rtl/calibration_pkg.sv - shared calibration state types and sizing helpers
//
// Purpose: state encodings shared by the calibration step FSM and the
// calibration sequencer, plus a width helper that never returns zero.
// Ports: none (package).
package calibration_pkg;

  // State of the per-bit-plane capture FSM; the sequencer only needs to
  // distinguish STEP_IDLE from everything else.
  typedef enum logic [1:0] {
    STEP_IDLE          = 2'd0,
    STEP_WAIT_FRAME    = 2'd1,
    STEP_CAPTURE_FRAME = 2'd2,
    STEP_ACCUMULATE    = 2'd3
  } calibration_step_state_t;

  typedef enum logic [2:0] {
    SEQ_IDLE        = 3'd0,
    SEQ_REQ_PATTERN = 3'd1,
    SEQ_FIRE        = 3'd2,
    SEQ_WAIT_LEAVE  = 3'd3,
    SEQ_WAIT_IDLE   = 3'd4,
    SEQ_ADVANCE     = 3'd5,
    SEQ_FINISH      = 3'd6
  } calibration_sequencer_state_t;

  // $clog2 that yields at least 1 so a degenerate parameter still gives a legal vector.
  function automatic int unsigned safe_clog2(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/calibration_sequencer.sv
// rtl/calibration_sequencer.sv - walks LED address bit planes through the capture step FSM
//
// Purpose: for each bit plane 0..LED_ADDRESS_WIDTH-1, ask the LED driver to show
// that plane, wait for its ack, fire one capture, and wait for it to complete.
// The first capture of a run pulses overwrite_latch_out so the accumulate RAM
// starts fresh.
// Ports:
//   clk_pixel, rst          pixel clock, synchronous active-high reset
//   start_in, abort_in      run request (level, IDLE only) / abandon run
//   step_state_in           state of the capture step FSM
//   pattern_req_out/ack_in  handshake with the LED pattern driver
//   bit_index_out           bit plane being displayed and captured
//   start_step_out          one-cycle capture start pulse
//   overwrite_latch_out     one-cycle pulse alongside the first capture start
//   busy_out, done_out      not-IDLE flag / end-of-run pulse
//   error_out               sticky pattern ack timeout
module calibration_sequencer
  import calibration_pkg::*;
#(
  parameter int unsigned LED_ADDRESS_WIDTH  = 10,
  parameter int unsigned ACK_TIMEOUT_CYCLES = 1000000,
  localparam int unsigned BIT_IDX_WIDTH     = safe_clog2(LED_ADDRESS_WIDTH)
) (
  input  logic                     clk_pixel,
  input  logic                     rst,
  input  logic                     start_in,
  input  logic                     abort_in,
  input  calibration_step_state_t  step_state_in,
  output logic                     pattern_req_out,
  input  logic                     pattern_ack_in,
  output logic [BIT_IDX_WIDTH-1:0] bit_index_out,
  output logic                     start_step_out,
  output logic                     overwrite_latch_out,
  output logic                     busy_out,
  output logic                     done_out,
  output logic                     error_out
);

  localparam int unsigned TIMER_WIDTH = safe_clog2(ACK_TIMEOUT_CYCLES);
  localparam logic [TIMER_WIDTH-1:0]   TIMER_LAST = TIMER_WIDTH'(ACK_TIMEOUT_CYCLES - 1);
  localparam logic [BIT_IDX_WIDTH-1:0] LAST_BIT   = BIT_IDX_WIDTH'(LED_ADDRESS_WIDTH - 1);

  calibration_sequencer_state_t r_state;
  logic [TIMER_WIDTH-1:0]       r_timer;
  logic [BIT_IDX_WIDTH-1:0]     r_bit_index;
  logic                         r_pattern_req;
  logic                         r_start_step;
  logic                         r_overwrite;
  logic                         r_busy;
  logic                         r_done;
  logic                         r_error;

  // Every output is a register updated alongside the state, so no input
  // reaches an output combinationally.
  always_ff @(posedge clk_pixel) begin
    if (rst) begin
      r_state       <= SEQ_IDLE;
      r_timer       <= '0;
      r_bit_index   <= '0;
      r_pattern_req <= 1'b0;
      r_start_step  <= 1'b0;
      r_overwrite   <= 1'b0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_error       <= 1'b0;
    end else begin
      r_start_step <= 1'b0;
      r_overwrite  <= 1'b0;
      r_done       <= 1'b0;
      if (abort_in) begin
        // Any capture already started finishes on its own; the IDLE check on
        // step_state_in keeps a new run from overlapping it.
        r_state       <= SEQ_IDLE;
        r_timer       <= '0;
        r_pattern_req <= 1'b0;
        r_busy        <= 1'b0;
      end else begin
        unique case (r_state)
          SEQ_IDLE: begin
            if (start_in && step_state_in == STEP_IDLE) begin
              r_bit_index   <= '0;
              r_error       <= 1'b0;
              r_timer       <= '0;
              r_pattern_req <= 1'b1;
              r_busy        <= 1'b1;
              r_state       <= SEQ_REQ_PATTERN;
            end
          end
          SEQ_REQ_PATTERN: begin
            // An ack on the final timer cycle still wins over the timeout.
            if (pattern_ack_in) begin
              r_pattern_req <= 1'b0;
              r_timer       <= '0;
              r_start_step  <= 1'b1;
              r_overwrite   <= (r_bit_index == '0);
              r_state       <= SEQ_FIRE;
            end else if (r_timer == TIMER_LAST) begin
              r_error       <= 1'b1;
              r_pattern_req <= 1'b0;
              r_timer       <= '0;
              r_busy        <= 1'b0;
              r_state       <= SEQ_IDLE;
            end else begin
              r_timer <= r_timer + TIMER_WIDTH'(1);
            end
          end
          SEQ_FIRE: begin
            r_state <= SEQ_WAIT_LEAVE;
          end
          SEQ_WAIT_LEAVE: begin
            if (step_state_in != STEP_IDLE) begin
              r_state <= SEQ_WAIT_IDLE;
            end
          end
          SEQ_WAIT_IDLE: begin
            if (step_state_in == STEP_IDLE) begin
              r_state <= SEQ_ADVANCE;
            end
          end
          SEQ_ADVANCE: begin
            // The only place bit_index moves, so the displayed pattern is
            // stable for the whole capture.
            if (r_bit_index == LAST_BIT) begin
              r_done  <= 1'b1;
              r_state <= SEQ_FINISH;
            end else begin
              r_bit_index   <= r_bit_index + BIT_IDX_WIDTH'(1);
              r_pattern_req <= 1'b1;
              r_state       <= SEQ_REQ_PATTERN;
            end
          end
          SEQ_FINISH: begin
            r_busy  <= 1'b0;
            r_state <= SEQ_IDLE;
          end
          default: begin
            r_pattern_req <= 1'b0;
            r_busy        <= 1'b0;
            r_state       <= SEQ_IDLE;
          end
        endcase
      end
    end
  end

  assign pattern_req_out     = r_pattern_req;
  assign bit_index_out       = r_bit_index;
  assign start_step_out      = r_start_step;
  assign overwrite_latch_out = r_overwrite;
  assign busy_out            = r_busy;
  assign done_out            = r_done;
  assign error_out           = r_error;

endmodule

// File: tb/tb_calibration_sequencer.sv
// tb/tb_calibration_sequencer.sv - scoreboard bench for calibration_sequencer
module tb_calibration_sequencer;
  import calibration_pkg::*;

  localparam int W      = 4;
  localparam int ACK_TO = 8;
  localparam int EV_STEP = 0;
  localparam int EV_DONE = 1;
  localparam int EV_ERR  = 2;

  logic clk_pixel = 1'b0;
  logic rst = 1'b1;
  logic start_in = 1'b0;
  logic abort_in = 1'b0;
  logic pattern_ack_in = 1'b0;
  calibration_step_state_t step_state_in = STEP_IDLE;
  logic pattern_req_out, start_step_out, overwrite_latch_out;
  logic busy_out, done_out, error_out;
  logic [1:0] bit_index_out;

  calibration_sequencer #(
    .LED_ADDRESS_WIDTH (W),
    .ACK_TIMEOUT_CYCLES(ACK_TO)
  ) dut (
    .clk_pixel          (clk_pixel),
    .rst                (rst),
    .start_in           (start_in),
    .abort_in           (abort_in),
    .step_state_in      (step_state_in),
    .pattern_req_out    (pattern_req_out),
    .pattern_ack_in     (pattern_ack_in),
    .bit_index_out      (bit_index_out),
    .start_step_out     (start_step_out),
    .overwrite_latch_out(overwrite_latch_out),
    .busy_out           (busy_out),
    .done_out           (done_out),
    .error_out          (error_out)
  );

  always #5 clk_pixel = ~clk_pixel;

  typedef struct {
    int kind;
    int bidx;
    int ovw;
  } ev_t;

  ev_t exp_q[$];
  int total = 0;
  int bad = 0;

  task automatic check(input string name, input int act, input int want);
    total++;
    if (act != want) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, act, want);
    end
  endtask

  // Reference model of a complete run: one capture per bit plane in order,
  // only the first overwriting, then a single done.
  task automatic push_run();
    ev_t e;
    for (int b = 0; b < W; b++) begin
      e.kind = EV_STEP; e.bidx = b; e.ovw = (b == 0) ? 1 : 0;
      exp_q.push_back(e);
    end
    e.kind = EV_DONE; e.bidx = 0; e.ovw = 0;
    exp_q.push_back(e);
  endtask

  task automatic expect_ev(input string name, input int kind, input int bidx, input int ovw);
    ev_t e;
    if (exp_q.size() == 0) begin
      total++;
      bad++;
      $display("FAIL %s_unexpected: got event kind %0d want none", name, kind);
    end else begin
      e = exp_q.pop_front();
      check({name, "_kind"}, kind, e.kind);
      if (e.kind == EV_STEP) begin
        check({name, "_bit"}, bidx, e.bidx);
        check({name, "_ovw"}, ovw, e.ovw);
      end
    end
  endtask

  // LED driver and step FSM models, driven just after each active edge.
  bit ack_en = 1'b1;
  bit spur_en = 1'b0;
  int ack_lat = 3;
  int dwell = 20;
  int leave_dly = 0;
  int ack_cnt = 0;
  int step_phase = 0;
  int step_cnt = 0;
  int spur_cnt = 0;
  int spur_chk = 0;
  int spur_bit = 0;

  always @(posedge clk_pixel) begin
    #1;
    pattern_ack_in = 1'b0;
    if (rst) begin
      ack_cnt = 0;
    end else if (pattern_req_out && ack_en) begin
      ack_cnt++;
      if (ack_cnt >= ack_lat) begin
        pattern_ack_in = 1'b1;
        ack_cnt = 0;
      end
    end else begin
      ack_cnt = 0;
    end
    case (step_phase)
      0: if (start_step_out) begin
        step_cnt = leave_dly;
        step_phase = 1;
        if (spur_en) begin
          spur_cnt = 2;
          spur_bit = int'(bit_index_out);
        end
      end
      1: if (step_cnt == 0) begin
        step_state_in = STEP_CAPTURE_FRAME;
        step_cnt = dwell;
        step_phase = 2;
      end else begin
        step_cnt--;
      end
      default: if (step_cnt == 0) begin
        step_state_in = STEP_IDLE;
        step_phase = 0;
      end else begin
        step_cnt--;
        if (step_cnt < 2) step_state_in = STEP_ACCUMULATE;
      end
    endcase
    if (spur_cnt > 0) begin
      spur_cnt--;
      if (spur_cnt == 0) begin
        pattern_ack_in = 1'b1;
        spur_chk = 3;
      end
    end else if (spur_chk > 0) begin
      spur_chk--;
      if (spur_chk == 0) begin
        check("spur_bit_index", int'(bit_index_out), spur_bit);
        check("spur_no_req", int'(pattern_req_out), 0);
      end
    end
  end

  // Monitor: pops the scoreboard whenever the DUT presents an event.
  bit prev_done = 1'b0;
  bit prev_err = 1'b0;

  always @(negedge clk_pixel) begin
    if (rst) begin
      prev_done = 1'b0;
      prev_err = 1'b0;
    end else begin
      if (start_step_out) begin
        expect_ev("step", EV_STEP, int'(bit_index_out), int'(overwrite_latch_out));
        check("step_req_low", int'(pattern_req_out), 0);
      end else if (overwrite_latch_out) begin
        check("ovw_without_step", 1, 0);
      end
      if (done_out) begin
        expect_ev("done", EV_DONE, 0, 0);
        check("busy_at_done", int'(busy_out), 1);
      end
      if (prev_done) check("busy_after_done", int'(busy_out), 0);
      if (error_out && !prev_err) expect_ev("error", EV_ERR, 0, 0);
      prev_done = done_out;
      prev_err = error_out;
    end
  end

  task automatic check_all_zero(input string name);
    check({name, "_req"}, int'(pattern_req_out), 0);
    check({name, "_start"}, int'(start_step_out), 0);
    check({name, "_ovw"}, int'(overwrite_latch_out), 0);
    check({name, "_busy"}, int'(busy_out), 0);
    check({name, "_done"}, int'(done_out), 0);
    check({name, "_err"}, int'(error_out), 0);
    check({name, "_bit"}, int'(bit_index_out), 0);
  endtask

  task automatic wait_quiet(input string name, input int budget);
    for (int i = 0; i < budget; i++) begin
      @(negedge clk_pixel);
      if (exp_q.size() == 0 && !busy_out && step_state_in == STEP_IDLE) break;
    end
    check({name, "_drained"}, exp_q.size(), 0);
    check({name, "_idle"}, int'(busy_out), 0);
  endtask

  task automatic do_run(input string name);
    @(negedge clk_pixel);
    start_in = 1'b1;
    push_run();
    @(negedge clk_pixel);
    start_in = 1'b0;
    check({name, "_req_next"}, int'(pattern_req_out), 1);
    check({name, "_busy"}, int'(busy_out), 1);
    check({name, "_err_clr"}, int'(error_out), 0);
    check({name, "_bit0"}, int'(bit_index_out), 0);
    wait_quiet(name, 4000);
  endtask

  task automatic wait_until_bit_event(input bit want_step, input int b, input int budget);
    for (int i = 0; i < budget; i++) begin
      @(negedge clk_pixel);
      if (want_step && start_step_out && int'(bit_index_out) == b) return;
      if (!want_step && pattern_req_out && int'(bit_index_out) == b) return;
    end
    check("wait_bit_timeout", 1, 0);
  endtask

  initial begin
    int n;
    repeat (3) @(negedge clk_pixel);
    check_all_zero("in_reset");
    rst = 1'b0;
    @(negedge clk_pixel);
    check_all_zero("after_reset");

    do_run("full");

    for (int r = 0; r < 5; r++) begin
      ack_lat = $urandom_range(1, 6);
      dwell = $urandom_range(2, 25);
      leave_dly = $urandom_range(0, 3);
      do_run("rand");
    end
    ack_lat = 3; dwell = 20; leave_dly = 0;

    // Ack timeout
    ack_en = 1'b0;
    @(negedge clk_pixel);
    start_in = 1'b1;
    begin
      ev_t e;
      e.kind = EV_ERR; e.bidx = 0; e.ovw = 0;
      exp_q.push_back(e);
    end
    @(negedge clk_pixel);
    start_in = 1'b0;
    n = 0;
    for (int i = 0; i < 50 && !error_out; i++) begin
      if (pattern_req_out) n++;
      @(negedge clk_pixel);
    end
    check("timeout_req_cycles", n, ACK_TO);
    check("timeout_err", int'(error_out), 1);
    check("timeout_req_drop", int'(pattern_req_out), 0);
    check("timeout_idle", int'(busy_out), 0);
    ack_en = 1'b1;
    do_run("after_timeout");

    // Abort while waiting for the bit-2 capture to complete
    @(negedge clk_pixel);
    start_in = 1'b1;
    push_run();
    @(negedge clk_pixel);
    start_in = 1'b0;
    wait_until_bit_event(1'b1, 2, 500);
    repeat (4) @(negedge clk_pixel);
    abort_in = 1'b1;
    exp_q.delete();
    @(negedge clk_pixel);
    abort_in = 1'b0;
    check("abort_busy", int'(busy_out), 0);
    check("abort_done", int'(done_out), 0);
    check("abort_req", int'(pattern_req_out), 0);
    start_in = 1'b1;
    repeat (3) @(negedge clk_pixel);
    check("abort_start_ignored_busy", int'(busy_out), 0);
    check("abort_start_ignored_req", int'(pattern_req_out), 0);
    for (int i = 0; i < 100 && step_state_in != STEP_IDLE; i++) @(negedge clk_pixel);
    push_run();
    @(negedge clk_pixel);
    start_in = 1'b0;
    check("restart_busy", int'(busy_out), 1);
    check("restart_bit", int'(bit_index_out), 0);
    wait_quiet("restart", 4000);

    // start_in held high: back-to-back runs
    @(negedge clk_pixel);
    start_in = 1'b1;
    push_run();
    push_run();
    for (int i = 0; i < 2000 && !done_out; i++) @(negedge clk_pixel);
    check("b2b_first_done", int'(done_out), 1);
    @(negedge clk_pixel);
    check("b2b_gap_req", int'(pattern_req_out), 0);
    check("b2b_gap_busy", int'(busy_out), 0);
    @(negedge clk_pixel);
    check("b2b_second_req", int'(pattern_req_out), 1);
    start_in = 1'b0;
    wait_quiet("b2b", 4000);

    // Spurious ack while waiting for the step FSM to leave IDLE
    spur_en = 1'b1;
    leave_dly = 4;
    do_run("spurious");
    spur_en = 1'b0;
    leave_dly = 0;

    // Reset in the middle of REQ_PATTERN for bit 2
    @(negedge clk_pixel);
    start_in = 1'b1;
    push_run();
    @(negedge clk_pixel);
    start_in = 1'b0;
    wait_until_bit_event(1'b0, 2, 500);
    rst = 1'b1;
    exp_q.delete();
    @(negedge clk_pixel);
    check_all_zero("mid_rst");
    rst = 1'b0;
    do_run("post_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/calibration_sequencer.md
# calibration_sequencer

Top-level controller for LED address calibration. It walks through bit planes 0..LED_ADDRESS_WIDTH-1 of the LED address. For each bit plane it:
- hands the LED pattern driver the bit index to display, and waits for the driver's acknowledge;
- fires one `calibration_step_fsm` capture;
- waits for that capture to finish.

The first capture of a run forces an overwrite of the shift-accumulate RAM, so each pixel ends up holding its full LED address. The block sits between the user start button and the calibration step FSM / LED strip driver, on the pixel clock.

## Interface
Parameters:
- LED_ADDRESS_WIDTH, 10: number of bit planes captured per run.
- ACK_TIMEOUT_CYCLES, 1000000: maximum wait for pattern_ack_in before an error is raised.
- BIT_IDX_WIDTH, $clog2(LED_ADDRESS_WIDTH) (localparam): width of the bit index.

Ports (reset rst, synchronous, active-high; clock clk_pixel):
- clk_pixel  in  1  pixel clock.
- rst  in  1  synchronous active-high reset.
- start_in  in  1  request a full calibration run; level-sampled, acted on only in IDLE.
- abort_in  in  1  abandon the current run.
- step_state_in  in  calibration_step_state_t (2)  state output of the step FSM.
- pattern_req_out  out  1  request the LED driver to display bit plane bit_index_out.
- pattern_ack_in  in  1  one-cycle pulse: the driver has latched the pattern onto the strip.
- bit_index_out  out  BIT_IDX_WIDTH  bit plane currently displayed/captured.
- start_step_out  out  1  one-cycle pulse to the step FSM start_calibration_step.
- overwrite_latch_out  out  1  one-cycle pulse to should_overwrite_latch; asserted with start_step_out only when bit_index_out==0.
- busy_out  out  1  high in every state except IDLE.
- done_out  out  1  one-cycle pulse when all bit planes have been captured.
- error_out  out  1  sticky ack timeout; cleared by rst or the next accepted start_in.

## Operation
States: IDLE, REQ_PATTERN, FIRE, WAIT_LEAVE, WAIT_IDLE, ADVANCE, FINISH.
- **IDLE:** on start_in && step_state_in==IDLE:
  - bit_index_out <= 0, error_out <= 0;
  - go to REQ_PATTERN.
  - start_in is ignored while step_state_in!=IDLE.
- **REQ_PATTERN:**
  - pattern_req_out held high and the ack timer counts.
  - On pattern_ack_in: drop the request, clear the timer, go to FIRE.
  - On timer==ACK_TIMEOUT_CYCLES-1: error_out <= 1, go to IDLE.
- **FIRE:** for exactly one cycle:
  - start_step_out=1;
  - overwrite_latch_out=(bit_index_out==0);
  - next state WAIT_LEAVE.
- **WAIT_LEAVE:** wait for step_state_in!=IDLE, then go to WAIT_IDLE. The step FSM leaves IDLE the cycle after the start pulse.
- **WAIT_IDLE:** wait for step_state_in==IDLE, meaning the capture has completed; then go to ADVANCE.
- **ADVANCE:**
  - if bit_index_out==LED_ADDRESS_WIDTH-1, go to FINISH;
  - else bit_index_out+1 and go to REQ_PATTERN.
- **FINISH:** done_out=1 for one cycle, then IDLE. bit_index_out keeps its final value until the next start.
- **abort_in** (any non-IDLE state): next cycle go to IDLE, with pattern_req_out, start_step_out and overwrite_latch_out low, and done_out not pulsed.
  - An in-flight step FSM capture is left to finish by itself.
  - A new run cannot begin until step_state_in returns to IDLE.
- **Priority:** rst > abort_in > state transitions. pattern_ack_in is ignored outside REQ_PATTERN.

## Timing
- Reset values: state IDLE, every output 0, bit_index_out 0, timer 0.
- All outputs are registered or decoded from the registered state only; there is no combinational path from any input to any output.
- start_in sampled at edge t leads to pattern_req_out high from t+1.
- pattern_ack_in at edge a leads to start_step_out high during cycle a+1 only.
- WAIT_LEAVE must tolerate step_state_in changing at any later cycle. There is no timeout, because the step FSM's camera wait is long.
- The LED pattern must remain stable through capture: bit_index_out changes only in ADVANCE.
- Per-run overhead beyond the step FSM captures is at most 4 cycles per bit plane plus ack latency.
- Timer width is $clog2(ACK_TIMEOUT_CYCLES). The timer saturates and never wraps.

## Structure
- calibration_step_state_t is shared with calibration_step_fsm.
- The new calibration_sequencer_state_t goes in a shared package, calibration_pkg, next to it.
- Single module with no sub-module. The ack timer is inline.

## Test plan
- **Full run**, LED_ADDRESS_WIDTH=4, driver acks 3 cycles after the request, step model dwells 20 cycles per capture:
  - exactly 4 start_step_out pulses with bit_index_out 0,1,2,3;
  - overwrite_latch_out only on the first;
  - done_out pulses once;
  - busy_out falls the cycle after done_out.
- **Ack timeout**, ACK_TIMEOUT_CYCLES=8, no ack: error_out rises at the 8th REQ_PATTERN cycle, state returns to IDLE, and start_step_out never pulses.
- **Abort during WAIT_IDLE at bit 2:**
  - next cycle busy_out=0 and no done_out;
  - start_in asserted while step_state_in is still CAPTURE_FRAME is ignored;
  - start_in accepted once step_state_in==IDLE, after which bit_index_out=0 and overwrite_latch_out fires again.
- **start_in held high continuously:** runs back-to-back with one IDLE cycle between done_out and the next pattern_req_out.
- **Spurious pattern_ack_in during WAIT_LEAVE:** no effect, and bit_index_out unchanged.
- **rst asserted mid-REQ_PATTERN:** next cycle all outputs 0 and bit_index_out 0; a subsequent start yields a clean 4-step run.
